// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B mod 2^WIDTH, borrow-out on BO, one bit per clock LSB first.
// Latency: start accepted at edge k -> done pulse between edges k+WIDTH and k+WIDTH+1; busy until k+WIDTH+1.
// Backpressure: start is only accepted in IDLE; it is ignored while busy, so holding it high re-accepts every WIDTH+2 edges.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; abandons any operation in flight
//   start - request a subtraction (sampled in IDLE only)
//   A, B  - minuend / subtrahend, captured on the accepting edge
//   D, BO - registered difference and final borrow, updated only on the done edge
//   busy  - high while an operation is in progress (state != IDLE)
//   done  - one-cycle pulse marking a new D/BO
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d_bit;
    logic             br_next;

    // Full-subtractor cell on the current LSBs. The result register fills from
    // the MSB side, so after WIDTH shifts bit 0 of the difference sits at bit 0.
    // Shift-then-overwrite keeps this legal for WIDTH=1.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next = res >> 1;
        res_next[WIDTH-1] = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            D     <= '0;
            BO    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_next;
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    // Publish only once every bit is processed so partial
                    // results never appear on D.
                    if (cnt == LAST) begin
                        D     <= res_next;
                        BO    <= br_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8, 4 and 1.
// Expected values are hand-computed constants or plain integer arithmetic.
// Outputs are sampled 1 time unit after the rising edge.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, start4, start1;
    logic [7:0] a8, b8, d8;
    logic [3:0] a4, b4, d4;
    logic [0:0] a1, b1, d1;
    logic       bo8, busy8, done8;
    logic       bo4, busy4, done4;
    logic       bo1, busy1, done1;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .D(d8), .BO(bo8), .busy(busy8), .done(done8)
    );
    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .D(d4), .BO(bo4), .busy(busy4), .done(done4)
    );
    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .D(d1), .BO(bo1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation with cycle-exact checks. Operands are scrambled
    // during RUN; optionally start is pulsed while busy.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                       input logic ebo, input logic pulse, input string tag);
        logic [7:0] d_prev;
        logic       bo_prev;
        logic       early_bad;
        d_prev    = d8;
        bo_prev   = bo8;
        early_bad = 1'b0;
        a8 = a; b8 = b; start8 = 1'b1;
        tick();                                   // edge k: accept
        start8 = 1'b0;
        check({tag, "_busy_k"}, busy8, 1);
        for (int i = 1; i < 8; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (pulse) start8 = i[0];
            tick();                               // edges k+1 .. k+7
            if (done8 !== 1'b0 || d8 !== d_prev || bo8 !== bo_prev || busy8 !== 1'b1)
                early_bad = 1'b1;
        end
        start8 = 1'b0;
        check({tag, "_early"}, early_bad, 0);
        tick();                                   // edge k+8
        check({tag, "_done"}, done8, 1);
        check({tag, "_D"}, d8, ed);
        check({tag, "_BO"}, bo8, ebo);
        tick();                                   // edge k+9
        check({tag, "_done_off"}, done8, 0);
        check({tag, "_busy_off"}, busy8, 0);
        check({tag, "_D_hold"}, d8, ed);
        tick();                                   // edge k+10, start low
        check({tag, "_idle"}, busy8, 0);
    endtask

    task automatic op4(input int a, input int b);
        int lat;
        lat = 0;
        a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (done4 === 1'b1) lat = i;
        end
        check("w4_latency", lat, 4);
        check("w4_D", d4, (a - b) & 32'hF);
        check("w4_BO", bo4, (a < b) ? 1 : 0);
        tick();
    endtask

    task automatic op1(input int a, input int b);
        int lat;
        lat = 0;
        a1 = 1'(a); b1 = 1'(b); start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            tick();
            if (done1 === 1'b1) lat = i;
        end
        check("w1_latency", lat, 1);
        check("w1_D", d1, (a - b) & 32'h1);
        check("w1_BO", bo1, (a < b) ? 1 : 0);
        tick();
    endtask

    initial begin
        logic early_bad;
        rst_n  = 1'b1;
        start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0; a1 = '0; b1 = '0;

        // Reset asserted off the clock edge takes effect immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_D", d8, 8'h00);
        check("rst_BO", bo8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        op8(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, "basic");
        op8(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "underflow");
        op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "ripple");
        op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "equal");
        op8(8'h44, 8'h11, 8'h33, 1'b0, 1'b1, "pulse");

        // start held high: operands scrambled during RUN, second accept at k+10.
        a8 = 8'hC3; b8 = 8'h3C; start8 = 1'b1;
        tick();                                   // edge k
        for (int i = 1; i < 8; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
        end
        a8 = 8'h01; b8 = 8'h02;
        tick();                                   // edge k+8
        check("hold_done", done8, 1);
        check("hold_D", d8, 8'h87);
        check("hold_BO", bo8, 0);
        tick();                                   // edge k+9
        check("hold_idle_k9", busy8, 0);
        tick();                                   // edge k+10: second accept
        check("hold_reaccept", busy8, 1);
        start8 = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        tick();                                   // edge k+18
        check("hold2_done", done8, 1);
        check("hold2_D", d8, 8'hFF);
        check("hold2_BO", bo8, 1);
        tick();
        tick();

        // Reset after bit 4 of an operation: outputs clear, no done follows.
        a8 = 8'h55; b8 = 8'h0F; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_D", d8, 8'h00);
        check("midrst_BO", bo8, 0);
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        tick();
        tick();
        rst_n = 1'b1;
        early_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) early_bad = 1'b1;
        end
        check("midrst_quiet", early_bad, 0);
        op8(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, "after_rst");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                op4(a, b);

        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                op1(a, b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes D = A - B mod 2^WIDTH and a borrow-out flag, one bit per clock, LSB first.
- Datapath per bit: one full-subtractor cell plus a borrow flip-flop. This is the arithmetic inverse of the combinational adder cells.
- Parallel-load front end with a start/busy/done handshake.
- Used where subtraction latency is acceptable and area is the constraint.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a subtraction; sampled on rising clk edges; accepted only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- D  output  WIDTH  difference A - B mod 2^WIDTH; registered.
- BO  output  1  final borrow; 1 iff A < B (unsigned); registered.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse marking D/BO valid for a new result.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE; D=0, BO=0, done=0, busy=0.
  - Internal operand shift registers, borrow FF and bit counter all cleared.
  - Reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 on an edge: load A and B into shift registers, borrow FF=0, counter=0, go to RUN.
  - Otherwise remain in IDLE.
  - D and BO hold the previous result.
- RUN, on each edge, with a0/b0 = current LSBs and br = borrow FF:
  - d_bit = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift both operand registers right by 1.
  - Shift d_bit into the result register from the MSB side.
  - Counter increments.
  - On the edge that processes bit WIDTH-1: copy the result register to D, set BO=br_next, set done=1, go to DONE.
- DONE: lasts exactly one cycle. On the next edge: done=0, go to IDLE.
- Latency:
  - If start is accepted at edge k, done is high between edges k+WIDTH and k+WIDTH+1.
  - busy is high from edge k to edge k+WIDTH+1.
  - With start held high, back-to-back operations accept at edges k, k+WIDTH+2, and so on.
- Handshake:
  - start is ignored in RUN and DONE.
  - A and B are don't-care after the accepting edge; changes mid-run must not affect the result.
- Output update timing:
  - D and BO change only on the done edge (or on reset); intermediate bits are never visible on D.
  - D and BO remain stable until the next done or reset.
- Width rules:
  - Counter width is clog2(WIDTH+1).
  - WIDTH=1 must work: RUN lasts one cycle.
- Arithmetic: unsigned. BO=1 exactly when the true difference is negative; D is then the two's-complement wrap.

Test Plan (WIDTH=8 unless noted):
- Reset: assert rst_n=0 at arbitrary time, not clock-aligned -> D=0x00, BO=0, busy=0, done=0 immediately.
- Basic subtraction: A=0x5A, B=0x23, start at edge k -> done at k+8, D=0x37, BO=0; busy low after k+9.
- Underflow: A=0x10, B=0x20 -> D=0xF0, BO=1.
- Full borrow ripple: A=0x00, B=0x01 -> D=0xFF, BO=1. Equal operands: A=B=0xFF -> D=0x00, BO=0.
- Handshake:
  - Hold start=1 and randomize A/B every cycle during RUN -> result matches the operands captured at the accepting edge.
  - Second accept occurs exactly 10 edges after the first.
  - Pulsing start during busy has no effect.
- Mid-run reset plus regression:
  - Pull rst_n low after bit 4 of an operation -> no done pulse; all outputs 0.
  - Following operation A=0x80, B=0x7F -> D=0x01, BO=0.
  - WIDTH=4: exhaustive 256 operand pairs vs the behavioural model (A-B)&0xF and A<B.
  - WIDTH=1: all 4 pairs.
